inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/isa_pkg.sv | 73 +++++++
 rtl/enc_fifo2.sv | 77 +++++++
 rtl/inst_encoder.sv | 226 ++++++++++++++++++++++
 tb/tb_inst_encoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared instruction-set definitions for the encoder and the decoder:
//   - field positions and widths of the 32-bit instruction word
//   - the format-select rule (opcode[2] = 1 -> I-format, 0 -> R-format)
//   - the encoder FSM state enumeration
//   - helper functions that build a word from fields and check field legality
// Word layout:
//   R-format: {opcode[31:29], r0[28:24], r1[23:19], r2[18:14], 14'b0}
//   I-format: {opcode[31:29], r0[28:24], r1[23:19], 3'b000, addr[15:0]}
// -----------------------------------------------------------------------------
package isa_pkg;

  localparam int INST_W     = 32;
  localparam int OPC_W      = 3;
  localparam int REG_W      = 5;
  localparam int ADDR_FLD_W = 16;

  localparam int OPC_LSB    = 29;
  localparam int R0_LSB     = 24;
  localparam int R1_LSB     = 19;
  localparam int R2_LSB     = 14;
  localparam int IMM_LSB    = 0;

  // Opcode bit that selects the instruction format.
  localparam int FMT_BIT    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } enc_state_e;

  typedef struct packed {
    logic [OPC_W-1:0]      opcode;
    logic [REG_W-1:0]      r0;
    logic [REG_W-1:0]      r1;
    logic [REG_W-1:0]      r2;
    logic [ADDR_FLD_W-1:0] addr;
  } inst_fields_t;

  // I-format when the format bit of the opcode is set.
  function automatic logic is_i_format(input logic [OPC_W-1:0] opcode);
    return opcode[FMT_BIT];
  endfunction

  // Build the instruction word; the field unused by the format is left zero.
  function automatic logic [INST_W-1:0] encode_inst(input inst_fields_t f);
    logic [INST_W-1:0] w;
    w                        = {INST_W{1'b0}};
    w[OPC_LSB +: OPC_W]      = f.opcode;
    w[R0_LSB  +: REG_W]      = f.r0;
    w[R1_LSB  +: REG_W]      = f.r1;
    if (is_i_format(f.opcode)) begin
      w[IMM_LSB +: ADDR_FLD_W] = f.addr;
    end else begin
      w[R2_LSB +: REG_W]       = f.r2;
    end
    return w;
  endfunction

  // A tuple is legal when the field its format does not use is zero.
  function automatic logic fields_legal(input inst_fields_t f);
    logic ok;
    if (is_i_format(f.opcode)) begin
      ok = (f.r2 == {REG_W{1'b0}});
    end else begin
      ok = (f.addr == {ADDR_FLD_W{1'b0}});
    end
    return ok;
  endfunction

endpackage

// File: rtl/enc_fifo2.sv
// -----------------------------------------------------------------------------
// enc_fifo2
// Two-entry FIFO holding encoded words between acceptance and memory write.
// slot0 is always the oldest entry, so the head output is a plain register
// and stays stable while the consumer stalls.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       synchronous empty (flush)
//   push, din   write a word (ignored when full, even if a pop happens too)
//   pop         remove the head (ignored when empty)
//   head        oldest word
//   count       occupancy 0..2
// -----------------------------------------------------------------------------
module enc_fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] slot0_r;
  logic [DATA_W-1:0] slot1_r;
  logic [1:0]        count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  // Qualify push/pop against current occupancy; a full FIFO never takes a push.
  always_comb begin
    push_ok_s = push && (count_r != 2'd2);
    pop_ok_s  = pop  && (count_r != 2'd0);
  end

  // Storage and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_r <= {DATA_W{1'b0}};
      slot1_r <= {DATA_W{1'b0}};
      count_r <= 2'd0;
    end else if (clear) begin
      slot0_r <= {DATA_W{1'b0}};
      slot1_r <= {DATA_W{1'b0}};
      count_r <= 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            slot0_r <= din;
          end else begin
            slot1_r <= din;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          slot0_r <= slot1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          // Both qualified implies exactly one entry: the new word becomes head.
          slot0_r <= din;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign head  = slot0_r;
  assign count = count_r;

endmodule

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
// Packs instruction field tuples into 32-bit words and streams them into an
// instruction memory through a 2-entry FIFO, tracking how many words were
// written and stopping once MEM_DEPTH words are in memory.
// Parameters:
//   MEM_DEPTH  number of memory words that may be written
//   ADDR_W     log2(MEM_DEPTH)
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid / in_ready            tuple handshake
//   in_opcode, in_r0, in_r1,
//   in_r2, in_addr                 instruction fields
//   flush                          synchronous clear of all state (wins over
//                                  same-cycle accept/write)
//   mem_we / mem_ready             memory write handshake
//   mem_waddr, mem_wdata           write address / FIFO head
//   wr_count                       number of completed writes
//   prog_full                      MEM_DEPTH words written
//   err                            sticky illegal-field flag
// Build option:
//   ENC_FIELD_CHECK_EN  when defined, tuples with a non-zero unused field
//                       are dropped and set err; otherwise err is 0.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module inst_encoder
  import isa_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [4:0]        in_r0,
  input  logic [4:0]        in_r1,
  input  logic [4:0]        in_r2,
  input  logic [15:0]       in_addr,
  input  logic              flush,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   wr_count,
  output logic              prog_full,
  output logic              err
);

  localparam logic [ADDR_W+1:0] DEPTH_C = (ADDR_W+2)'(MEM_DEPTH);

  enc_state_e         state_r;
  enc_state_e         state_nxt_s;

  logic               in_ready_r;
  logic               mem_we_r;
  logic               prog_full_r;
  logic               err_r;
  logic [ADDR_W-1:0]  mem_waddr_r;
  logic [ADDR_W:0]    wr_count_r;

  inst_fields_t       fields_s;
  logic [INST_W-1:0]  enc_word_s;
  logic [INST_W-1:0]  fifo_head_s;
  logic [1:0]         fifo_count_s;
  logic [1:0]         fifo_count_nxt_s;
  logic [ADDR_W:0]    wr_count_nxt_s;
  logic [ADDR_W+1:0]  committed_nxt_s;

  logic               accept_s;
  logic               legal_s;
  logic               push_s;
  logic               pop_s;
  logic               err_nxt_s;
  logic               in_ready_nxt_s;
  logic               mem_we_nxt_s;

  // Encode the offered tuple and decide what enters and leaves the FIFO.
  always_comb begin
    fields_s.opcode = in_opcode;
    fields_s.r0     = in_r0;
    fields_s.r1     = in_r1;
    fields_s.r2     = in_r2;
    fields_s.addr   = in_addr;
    enc_word_s      = encode_inst(fields_s);
    accept_s        = in_valid && in_ready_r;
`ifdef ENC_FIELD_CHECK_EN
    legal_s         = fields_legal(fields_s);
`else
    legal_s         = 1'b1;
`endif
    push_s          = accept_s && legal_s && !flush;
    pop_s           = mem_we_r && mem_ready && !flush;
  end

  // Sticky error flag for dropped tuples.
  always_comb begin
    err_nxt_s = err_r;
`ifdef ENC_FIELD_CHECK_EN
    if (flush) begin
      err_nxt_s = 1'b0;
    end else if (accept_s && !legal_s) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = err_r;
    end
`else
    err_nxt_s = 1'b0;
`endif
  end

  // Next occupancy and next completed-write count.
  always_comb begin
    fifo_count_nxt_s = fifo_count_s;
    wr_count_nxt_s   = wr_count_r;
    if (flush) begin
      fifo_count_nxt_s = 2'd0;
      wr_count_nxt_s   = {(ADDR_W+1){1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   fifo_count_nxt_s = fifo_count_s + 2'd1;
        2'b01:   fifo_count_nxt_s = fifo_count_s - 2'd1;
        default: fifo_count_nxt_s = fifo_count_s;
      endcase
      if (pop_s) begin
        wr_count_nxt_s = wr_count_r + (ADDR_W+1)'(1);
      end else begin
        wr_count_nxt_s = wr_count_r;
      end
    end
  end

  // FSM next state: FULL is entered on the last write and left only by flush/reset.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (push_s) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (pop_s && ({1'b0, wr_count_nxt_s} == DEPTH_C)) begin
            state_nxt_s = ST_FULL;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end
        ST_FULL: begin
          state_nxt_s = ST_FULL;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Next handshake outputs. A tuple is only accepted if memory still has room
  // for it after everything already written or queued, so no word is ever
  // accepted that could not be written.
  always_comb begin
    committed_nxt_s = {1'b0, wr_count_nxt_s} + {{ADDR_W{1'b0}}, fifo_count_nxt_s};
    in_ready_nxt_s  = (fifo_count_nxt_s != 2'd2) &&
                      (state_nxt_s != ST_FULL) &&
                      (committed_nxt_s < DEPTH_C);
    mem_we_nxt_s    = (fifo_count_nxt_s != 2'd0) && (state_nxt_s != ST_FULL);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered status and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      prog_full_r <= 1'b0;
      err_r       <= 1'b0;
      wr_count_r  <= {(ADDR_W+1){1'b0}};
      mem_waddr_r <= {ADDR_W{1'b0}};
    end else begin
      in_ready_r  <= in_ready_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      prog_full_r <= (state_nxt_s == ST_FULL);
      err_r       <= err_nxt_s;
      wr_count_r  <= wr_count_nxt_s;
      // The write pointer is the completed-write count modulo the depth.
      mem_waddr_r <= wr_count_nxt_s[ADDR_W-1:0];
    end
  end

  enc_fifo2 #(
    .DATA_W (INST_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (push_s),
    .pop   (pop_s),
    .din   (enc_word_s),
    .head  (fifo_head_s),
    .count (fifo_count_s)
  );

  assign in_ready  = in_ready_r;
  assign mem_we    = mem_we_r;
  assign mem_waddr = mem_waddr_r;
  assign mem_wdata = fifo_head_s;
  assign wr_count  = wr_count_r;
  assign prog_full = prog_full_r;
  assign err       = err_r;

endmodule

// File: tb/tb_inst_encoder.sv
`timescale 1ns/1ps
module tb_inst_encoder;
  import isa_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_opcode;
  logic [4:0]    in_r0, in_r1, in_r2;
  logic [15:0]   in_addr;
  logic          flush;
  logic          mem_we;
  logic          mem_ready;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   wr_count;
  logic          prog_full;
  logic          err;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: queued words, completed writes, full and error flags.
  logic [31:0] m_q[$];
  int          m_wr;
  bit          m_full;
  bit          m_err;
  bit          m_post_rst;

  always #5 clk = ~clk;

  inst_encoder #(.MEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_r0(in_r0), .in_r1(in_r1), .in_r2(in_r2),
    .in_addr(in_addr), .flush(flush), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .wr_count(wr_count),
    .prog_full(prog_full), .err(err)
  );

  function automatic logic [31:0] ref_enc(input logic [2:0] op, input logic [4:0] a,
                                          input logic [4:0] b, input logic [4:0] c,
                                          input logic [15:0] ad);
    logic [31:0] v;
    v = 32'(op) * 32'd536870912 + 32'(a) * 32'd16777216 + 32'(b) * 32'd524288;
    if (op >= 3'd4) v = v + 32'(ad);
    else            v = v + 32'(c) * 32'd16384;
    return v;
  endfunction

`ifdef ENC_FIELD_CHECK_EN
  function automatic bit ref_legal(input logic [2:0] op, input logic [4:0] c, input logic [15:0] ad);
    return (op >= 3'd4) ? (c == 5'd0) : (ad == 16'd0);
  endfunction
`endif

  function automatic bit exp_in_ready();
    return !m_post_rst && (m_q.size() < 2) && !m_full && ((m_wr + m_q.size()) < DEPTH);
  endfunction

  function automatic bit exp_mem_we();
    return (m_q.size() > 0) && !m_full;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_wr = 0; m_full = 1'b0; m_err = 1'b0; m_post_rst = 1'b1;
  endtask

  task automatic drive(input bit v, input logic [2:0] op, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] c, input logic [15:0] ad);
    in_valid = v; in_opcode = op; in_r0 = a; in_r1 = b; in_r2 = c; in_addr = ad;
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then settle.
  task automatic tick();
    bit acc, wr;
    @(posedge clk);
    acc = in_valid && exp_in_ready();
    wr  = exp_mem_we() && mem_ready;
    if (flush) begin
      m_q.delete(); m_wr = 0; m_full = 1'b0; m_err = 1'b0;
    end else begin
      if (wr) begin
        void'(m_q.pop_front());
        m_wr++;
        if (m_wr == DEPTH) m_full = 1'b1;
      end
      if (acc) begin
`ifdef ENC_FIELD_CHECK_EN
        if (!ref_legal(in_opcode, in_r2, in_addr)) m_err = 1'b1;
        else m_q.push_back(ref_enc(in_opcode, in_r0, in_r1, in_r2, in_addr));
`else
        m_q.push_back(ref_enc(in_opcode, in_r0, in_r1, in_r2, in_addr));
`endif
      end
    end
    m_post_rst = 1'b0;
    #1;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b0; mem_ready = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0);
    repeat (3) @(negedge clk);
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
    compared++; if (mem_waddr !== 2'd0) begin mismatched++; $display("FAIL rst_waddr: got %0d expected 0", mem_waddr); end
    compared++; if (mem_wdata !== 32'd0) begin mismatched++; $display("FAIL rst_wdata: got %h expected 0", mem_wdata); end
    compared++; if (wr_count !== 3'd0) begin mismatched++; $display("FAIL rst_wr_count: got %0d expected 0", wr_count); end
    compared++; if (prog_full !== 1'b0 || err !== 1'b0) begin mismatched++; $display("FAIL rst_flags: got full=%b err=%b expected 0 0", prog_full, err); end
    model_reset();
    rst_n = 1'b1;
    tick();
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_iformat();
    logic [31:0] w;
    @(negedge clk);
    mem_ready = 1'b0;
    drive(1'b1, 3'd7, 5'd0, 5'd31, 5'd0, 16'h3FFF);
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL i_latency: got mem_we=%b expected 0", mem_we); end
    tick();
    @(negedge clk);
    in_valid = 1'b0;
    compared++; if (mem_we !== 1'b1) begin mismatched++; $display("FAIL i_we: got %b expected 1", mem_we); end
    compared++; if (mem_wdata !== 32'hE0F83FFF) begin mismatched++; $display("FAIL i_wdata: got %h expected e0f83fff", mem_wdata); end
    compared++; if (mem_waddr !== 2'd0) begin mismatched++; $display("FAIL i_waddr: got %0d expected 0", mem_waddr); end
    w = mem_wdata;
    compared++;
    if (w[31:29] !== 3'd7 || w[28:24] !== 5'd0 || w[23:19] !== 5'd31 || w[15:0] !== 16'h3FFF || w[18:16] !== 3'd0) begin
      mismatched++;
      $display("FAIL i_decode: got op=%0d r0=%0d r1=%0d addr=%h expected 7 0 31 3fff", w[31:29], w[28:24], w[23:19], w[15:0]);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    compared++; if (wr_count !== 3'd1 || mem_we !== 1'b0) begin mismatched++; $display("FAIL i_complete: got wr_count=%0d we=%b expected 1 0", wr_count, mem_we); end
    do_flush();
    compared++; if (wr_count !== 3'd0) begin mismatched++; $display("FAIL i_flush_count: got %0d expected 0", wr_count); end
  endtask

  task automatic test_rformat();
    @(negedge clk);
    drive(1'b1, 3'd1, 5'd2, 5'd3, 5'd4, 16'd0);
    tick();
    @(negedge clk);
    in_valid = 1'b0;
    compared++; if (mem_wdata !== 32'h22190000) begin mismatched++; $display("FAIL r_wdata: got %h expected 22190000", mem_wdata); end
    do_flush();
  endtask

  task automatic test_backpressure();
    logic [31:0] w0, w1, w2;
    w0 = ref_enc(3'd1, 5'd1, 5'd2, 5'd3, 16'd0);
    w1 = ref_enc(3'd5, 5'd4, 5'd5, 5'd0, 16'h1234);
    w2 = ref_enc(3'd2, 5'd7, 5'd8, 5'd9, 16'd0);
    @(negedge clk); mem_ready = 1'b0;
    drive(1'b1, 3'd1, 5'd1, 5'd2, 5'd3, 16'd0); tick();
    @(negedge clk); drive(1'b1, 3'd5, 5'd4, 5'd5, 5'd0, 16'h1234); tick();
    @(negedge clk); drive(1'b1, 3'd2, 5'd7, 5'd8, 5'd9, 16'd0);
    for (int i = 0; i < 3; i++) begin
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_ready_low: got %b expected 0", in_ready); end
      compared++; if (mem_we !== 1'b1 || mem_wdata !== w0) begin mismatched++; $display("FAIL bp_stable: got we=%b wdata=%h expected 1 %h", mem_we, mem_wdata, w0); end
      tick();
    end
    @(negedge clk); mem_ready = 1'b1;
    compared++; if (mem_waddr !== 2'd0 || mem_wdata !== w0) begin mismatched++; $display("FAIL bp_wr0: got %0d %h expected 0 %h", mem_waddr, mem_wdata, w0); end
    tick();
    compared++; if (mem_waddr !== 2'd1 || mem_wdata !== w1 || in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_wr1: got %0d %h rdy=%b expected 1 %h 1", mem_waddr, mem_wdata, in_ready, w1); end
    tick();
    @(negedge clk); in_valid = 1'b0;
    compared++; if (mem_waddr !== 2'd2 || mem_wdata !== w2) begin mismatched++; $display("FAIL bp_wr2: got %0d %h expected 2 %h", mem_waddr, mem_wdata, w2); end
    tick();
    compared++; if (mem_we !== 1'b0 || wr_count !== 3'd3) begin mismatched++; $display("FAIL bp_done: got we=%b wr_count=%0d expected 0 3", mem_we, wr_count); end
    do_flush();
  endtask

  task automatic test_full();
    int idx, acc_cnt;
    bit rdy;
    idx = 0; acc_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      if (idx < 5) drive(1'b1, 3'(idx), 5'(idx + 1), 5'd9, 5'd0, 16'd0);
      else         in_valid = 1'b0;
      rdy = in_ready;
      if (idx == 4) begin
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL full_5th_ready: got %b expected 0", in_ready); end
      end
      tick();
      if (in_valid && rdy) begin acc_cnt++; idx++; end
      compared++; if (prog_full !== m_full) begin mismatched++; $display("FAIL full_flag_cycle: got %b expected %b", prog_full, m_full); end
    end
    in_valid = 1'b0;
    compared++; if (acc_cnt != 4) begin mismatched++; $display("FAIL full_accepts: got %0d expected 4", acc_cnt); end
    compared++; if (prog_full !== 1'b1 || wr_count !== 3'd4 || mem_we !== 1'b0) begin mismatched++; $display("FAIL full_final: got full=%b cnt=%0d we=%b expected 1 4 0", prog_full, wr_count, mem_we); end
    do_flush();
    compared++; if (prog_full !== 1'b0 || in_ready !== 1'b1) begin mismatched++; $display("FAIL full_flush: got full=%b rdy=%b expected 0 1", prog_full, in_ready); end
  endtask

  task automatic test_flush_reset();
    @(negedge clk); mem_ready = 1'b1; drive(1'b1, 3'd3, 5'd1, 5'd1, 5'd1, 16'd0); tick();
    @(negedge clk); in_valid = 1'b0; tick();
    @(negedge clk); mem_ready = 1'b0; drive(1'b1, 3'd4, 5'd2, 5'd2, 5'd0, 16'h00AA); tick();
    @(negedge clk);
    flush = 1'b1; mem_ready = 1'b1; drive(1'b1, 3'd2, 5'd3, 5'd3, 5'd3, 16'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    compared++; if (wr_count !== 3'd0 || mem_we !== 1'b0 || mem_waddr !== 2'd0) begin mismatched++; $display("FAIL flush_clear: got cnt=%0d we=%b addr=%0d expected 0 0 0", wr_count, mem_we, mem_waddr); end
    compared++; if (dut.state_r !== ST_IDLE) begin mismatched++; $display("FAIL flush_state: got %0d expected %0d", dut.state_r, ST_IDLE); end
    tick();
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL flush_drop: got we=%b expected 0", mem_we); end
    // async reset while a word waits for the memory
    @(negedge clk); mem_ready = 1'b1; drive(1'b1, 3'd0, 5'd5, 5'd5, 5'd5, 16'd0); tick();
    @(negedge clk); mem_ready = 1'b0; drive(1'b1, 3'd6, 5'd6, 5'd6, 5'd0, 16'h0042); tick();
    @(negedge clk); in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    compared++; if (mem_we !== 1'b0 || wr_count !== 3'd0 || in_ready !== 1'b0 || mem_wdata !== 32'd0) begin mismatched++; $display("FAIL rst_mid: got we=%b cnt=%0d rdy=%b wdata=%h expected 0 0 0 0", mem_we, wr_count, in_ready, mem_wdata); end
    compared++; if (dut.state_r !== ST_IDLE) begin mismatched++; $display("FAIL rst_mid_state: got %0d expected %0d", dut.state_r, ST_IDLE); end
    model_reset();
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    compared++; if (mem_we !== 1'b0 || wr_count !== 3'd0 || in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_after: got we=%b cnt=%0d rdy=%b expected 0 0 1", mem_we, wr_count, in_ready); end
  endtask

  task automatic test_field_check();
    @(negedge clk); mem_ready = 1'b0;
    drive(1'b1, 3'd1, 5'd1, 5'd1, 5'd1, 16'h0001);
    tick();
    @(negedge clk); in_valid = 1'b0;
`ifdef ENC_FIELD_CHECK_EN
    compared++; if (err !== 1'b1 || mem_we !== 1'b0) begin mismatched++; $display("FAIL fc_drop: got err=%b we=%b expected 1 0", err, mem_we); end
    drive(1'b1, 3'd3, 5'd4, 5'd5, 5'd6, 16'd0);
    tick();
    @(negedge clk); in_valid = 1'b0;
    compared++; if (mem_we !== 1'b1 || mem_waddr !== 2'd0 || mem_wdata !== ref_enc(3'd3, 5'd4, 5'd5, 5'd6, 16'd0) || err !== 1'b1) begin mismatched++; $display("FAIL fc_next: got we=%b addr=%0d wdata=%h err=%b", mem_we, mem_waddr, mem_wdata, err); end
`else
    compared++; if (err !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 32'h21084000) begin mismatched++; $display("FAIL fc_ignore: got err=%b we=%b wdata=%h expected 0 1 21084000", err, mem_we, mem_wdata); end
`endif
    do_flush();
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL fc_flush_err: got %b expected 0", err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 3) != 0, 3'($urandom), 5'($urandom), 5'($urandom),
            ($urandom_range(0, 1) != 0) ? 5'd0 : 5'($urandom),
            ($urandom_range(0, 1) != 0) ? 16'd0 : 16'($urandom));
      mem_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
      flush = 1'b0;
      compared++; if (in_ready !== exp_in_ready()) begin mismatched++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, in_ready, exp_in_ready()); end
      compared++; if (mem_we !== exp_mem_we()) begin mismatched++; $display("FAIL rnd_we[%0d]: got %b expected %b", i, mem_we, exp_mem_we()); end
      if (exp_mem_we()) begin
        compared++; if (mem_wdata !== m_q[0]) begin mismatched++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", i, mem_wdata, m_q[0]); end
      end
      compared++; if (mem_waddr !== 2'(m_wr % DEPTH) || wr_count !== 3'(m_wr)) begin mismatched++; $display("FAIL rnd_count[%0d]: got addr=%0d cnt=%0d expected %0d %0d", i, mem_waddr, wr_count, m_wr % DEPTH, m_wr); end
      compared++; if (prog_full !== m_full || err !== m_err) begin mismatched++; $display("FAIL rnd_flags[%0d]: got full=%b err=%b expected %b %b", i, prog_full, err, m_full, m_err); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_iformat();
    test_rformat();
    test_backpressure();
    test_full();
    test_flush_reset();
    test_field_check();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
